// File: rtl/cellrv32_npu_mmu_sequencer_pkg.sv
// cellrv32_npu_package: shared NPU types and default parameters.
// This file holds the MMU sequencer state encoding and its timing defaults.
package cellrv32_npu_package;
   localparam int MATRIX_WIDTH_DEFAULT   = 14;
   localparam int RESULT_LATENCY_DEFAULT = 30;
   localparam int CNT_WIDTH_DEFAULT      = 16;
   typedef enum logic [2:0] {IDLE, LOAD_W, FEED, DRAIN, DONE} npu_mmu_seq_state_t;
endpackage

// File: rtl/cellrv32_npu_mmu_sequencer_if.sv
// cellrv32_npu_mmu_sequencer_if: job config/status, buffer reads, MMU control and result strobe.
// The master side issues jobs and serves the buffers; the slave side is the sequencer.
interface cellrv32_npu_mmu_sequencer_if #(
   parameter int CNT_WIDTH = cellrv32_npu_package::CNT_WIDTH_DEFAULT
);
   logic                 start_i, load_wei_i, wei_signed_i, sys_signed_i, accumulate_i;
   logic [CNT_WIDTH-1:0] wei_base_i, in_base_i, acc_base_i, num_vec_i;
   logic                 busy_o, done_o, wbuf_rd_en_o, in_rd_en_o, mmu_enable_o;
   logic [CNT_WIDTH-1:0] wbuf_addr_o, in_addr_o, res_addr_o;
   logic                 mmu_load_wei_o, mmu_wei_signed_o, mmu_act_wei_o, mmu_sys_signed_o;
   logic [7:0]           mmu_wei_addr_o;
   logic                 res_valid_o, res_accumulate_o;
   modport master (
      output start_i, load_wei_i, wei_signed_i, sys_signed_i, accumulate_i,
             wei_base_i, in_base_i, acc_base_i, num_vec_i,
      input  busy_o, done_o, wbuf_rd_en_o, wbuf_addr_o, in_rd_en_o, in_addr_o, mmu_enable_o,
             mmu_load_wei_o, mmu_wei_addr_o, mmu_wei_signed_o, mmu_act_wei_o, mmu_sys_signed_o,
             res_valid_o, res_addr_o, res_accumulate_o
   );
   modport slave (
      input  start_i, load_wei_i, wei_signed_i, sys_signed_i, accumulate_i,
             wei_base_i, in_base_i, acc_base_i, num_vec_i,
      output busy_o, done_o, wbuf_rd_en_o, wbuf_addr_o, in_rd_en_o, in_addr_o, mmu_enable_o,
             mmu_load_wei_o, mmu_wei_addr_o, mmu_wei_signed_o, mmu_act_wei_o, mmu_sys_signed_o,
             res_valid_o, res_addr_o, res_accumulate_o
   );
endinterface

// File: rtl/cellrv32_npu_valid_delay.sv
// cellrv32_npu_valid_delay: fixed-depth shift register carrying {valid, addr, accumulate}.
// Models the MMU pipeline so result strobes line up with the array output.
module cellrv32_npu_valid_delay #(
   parameter int DEPTH     = 30,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 valid_i,
   input  logic [CNT_WIDTH-1:0] addr_i,
   input  logic                 acc_i,
   output logic                 valid_o,
   output logic [CNT_WIDTH-1:0] addr_o,
   output logic                 acc_o
);
   logic [CNT_WIDTH+1:0] pipe_q [DEPTH];
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= {valid_i, addr_i, acc_i};
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end
   assign {valid_o, addr_o, acc_o} = pipe_q[DEPTH-1];
endmodule

// File: rtl/cellrv32_npu_mmu_sequencer.sv
// cellrv32_npu_mmu_sequencer: job controller for the NPU matrix multiply unit.
// Preloads a weight tile, streams input vectors and emits latency-aligned result strobes.
module cellrv32_npu_mmu_sequencer
   import cellrv32_npu_package::*;
#(
   parameter int MATRIX_WIDTH   = MATRIX_WIDTH_DEFAULT,
   parameter int RESULT_LATENCY = RESULT_LATENCY_DEFAULT,
   parameter int CNT_WIDTH      = CNT_WIDTH_DEFAULT
) (
   input logic                         clk_i,
   input logic                         rstn_i,
   cellrv32_npu_mmu_sequencer_if.slave bus
);
   typedef logic [CNT_WIDTH-1:0] cnt_t;
   npu_mmu_seq_state_t state_q, state_d;
   cnt_t       cnt_q, cnt_d, wei_base_q, in_base_q, acc_base_q, num_vec_q, res_addr;
   logic       load_wei_q, wei_signed_q, sys_signed_q, accumulate_q;
   logic       load_q, act_q, feed, res_valid, res_acc;
   logic [7:0] row_q;
   assign feed = state_q == FEED;
   cellrv32_npu_valid_delay #(.DEPTH(RESULT_LATENCY), .CNT_WIDTH(CNT_WIDTH)) u_delay (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .valid_i (feed),
      .addr_i  (feed ? acc_base_q + cnt_q : '0),
      .acc_i   (feed & accumulate_q),
      .valid_o (res_valid),
      .addr_o  (res_addr),
      .acc_o   (res_acc)
   );
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         load_q       <= 1'b0;
         row_q        <= '0;
         act_q        <= 1'b0;
         load_wei_q   <= 1'b0;
         wei_signed_q <= 1'b0;
         sys_signed_q <= 1'b0;
         accumulate_q <= 1'b0;
         wei_base_q   <= '0;
         in_base_q    <= '0;
         acc_base_q   <= '0;
         num_vec_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         // Weight rows reach the MMU one cycle after their buffer read.
         load_q  <= state_q == LOAD_W;
         row_q   <= cnt_q[7:0];
         act_q   <= feed && cnt_q == '0 && load_wei_q;
         if (state_q == IDLE && bus.start_i) begin
            load_wei_q   <= bus.load_wei_i;
            wei_signed_q <= bus.wei_signed_i;
            sys_signed_q <= bus.sys_signed_i;
            accumulate_q <= bus.accumulate_i;
            wei_base_q   <= bus.wei_base_i;
            in_base_q    <= bus.in_base_i;
            acc_base_q   <= bus.acc_base_i;
            num_vec_q    <= bus.num_vec_i;
         end
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (bus.start_i) begin
            state_d = bus.load_wei_i ? LOAD_W : bus.num_vec_i != '0 ? FEED : DONE;
            cnt_d   = '0;
         end
         LOAD_W: begin
            state_d = cnt_q == cnt_t'(MATRIX_WIDTH - 1) ? (num_vec_q != '0 ? FEED : DONE) : LOAD_W;
            cnt_d   = cnt_q == cnt_t'(MATRIX_WIDTH - 1) ? '0 : cnt_q + cnt_t'(1);
         end
         FEED: begin
            state_d = cnt_q == num_vec_q - cnt_t'(1) ? DRAIN : FEED;
            cnt_d   = cnt_q == num_vec_q - cnt_t'(1) ? '0 : cnt_q + cnt_t'(1);
         end
         // Addresses within one job are unique, so the last one marks the end of the burst.
         DRAIN: state_d = res_valid && res_addr == acc_base_q + num_vec_q - cnt_t'(1) ? DONE : DRAIN;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      bus.busy_o           = state_q inside {LOAD_W, FEED, DRAIN};
      bus.mmu_enable_o     = state_q inside {LOAD_W, FEED, DRAIN};
      bus.done_o           = state_q == DONE;
      bus.wbuf_rd_en_o     = state_q == LOAD_W;
      bus.wbuf_addr_o      = state_q == LOAD_W ? wei_base_q + cnt_q : '0;
      bus.in_rd_en_o       = feed;
      bus.in_addr_o        = feed ? in_base_q + cnt_q : '0;
      bus.mmu_load_wei_o   = load_q;
      bus.mmu_wei_addr_o   = load_q ? row_q : '0;
      bus.mmu_wei_signed_o = wei_signed_q;
      bus.mmu_act_wei_o    = act_q;
      bus.mmu_sys_signed_o = sys_signed_q;
      bus.res_valid_o      = res_valid;
      bus.res_addr_o       = res_addr;
      bus.res_accumulate_o = res_acc;
   end
endmodule

// File: tb/tb_cellrv32_npu_mmu_sequencer.sv
// tb_cellrv32_npu_mmu_sequencer: job-level scoreboard bench for the MMU sequencer.
// Each job's expected strobe timeline is queued at issue; a negedge monitor pops and compares.
module tb_cellrv32_npu_mmu_sequencer;
   import cellrv32_npu_package::*;
   localparam int MW   = MATRIX_WIDTH_DEFAULT;
   localparam int RL   = RESULT_LATENCY_DEFAULT;
   localparam int MASK = 'hFFFF;
   typedef struct {int c; int v;} ev_t;
   logic  clk = 1'b0;
   logic  rstn_i = 1'b1;
   int    cyc = 0, checks = 0, errors = 0, busy_lo = 0, busy_hi = 0;
   bit    cur_ss, exp_busy;
   ev_t   evq [6][$];
   string nm [6] = '{"wbuf", "load_wei", "in_rd", "act_wei", "res", "done"};
   cellrv32_npu_mmu_sequencer_if bus ();
   cellrv32_npu_mmu_sequencer dut (.clk_i(clk), .rstn_i(rstn_i), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic push(input int k, input int c, input int v);
      ev_t e;
      e.c = c;
      e.v = v;
      evq[k].push_back(e);
   endtask
   task automatic chk_ev(input int k, input int v);
      ev_t e;
      checks++;
      if (evq[k].size() == 0) begin
         errors++;
         $display("FAIL %s unexpected at cycle %0d value %0h, required no strobe", nm[k], cyc, v);
      end else begin
         e = evq[k].pop_front();
         if (e.c != cyc || e.v != v) begin
            errors++;
            $display("FAIL %s got cycle %0d value %0h, required cycle %0d value %0h", nm[k], cyc, v, e.c, e.v);
         end
      end
   endtask
   always @(negedge clk) begin
      if (!rstn_i) begin
         checks++;
         if (|{bus.busy_o, bus.done_o, bus.wbuf_rd_en_o, bus.wbuf_addr_o, bus.in_rd_en_o, bus.in_addr_o,
               bus.mmu_enable_o, bus.mmu_load_wei_o, bus.mmu_wei_addr_o, bus.mmu_wei_signed_o,
               bus.mmu_act_wei_o, bus.mmu_sys_signed_o, bus.res_valid_o, bus.res_addr_o,
               bus.res_accumulate_o}) begin
            errors++;
            $display("FAIL reset_outs got nonzero output at cycle %0d, required all zero", cyc);
         end
      end else begin
         exp_busy = cyc >= busy_lo && cyc < busy_hi;
         checks++;
         if (bus.busy_o !== exp_busy || bus.mmu_enable_o !== exp_busy) begin
            errors++;
            $display("FAIL busy got %b/%b at cycle %0d, required %b", bus.busy_o, bus.mmu_enable_o, cyc, exp_busy);
         end
         if (exp_busy) begin
            checks++;
            if (bus.mmu_sys_signed_o !== cur_ss) begin
               errors++;
               $display("FAIL sys_signed got %b at cycle %0d, required %b", bus.mmu_sys_signed_o, cyc, cur_ss);
            end
         end
         if (bus.wbuf_rd_en_o) chk_ev(0, int'(bus.wbuf_addr_o));
         if (bus.mmu_load_wei_o) chk_ev(1, int'(bus.mmu_wei_addr_o));
         if (bus.in_rd_en_o) chk_ev(2, int'(bus.in_addr_o));
         if (bus.mmu_act_wei_o) chk_ev(3, 0);
         if (bus.res_valid_o) chk_ev(4, int'({bus.res_accumulate_o, bus.res_addr_o}));
         if (bus.done_o) chk_ev(5, int'({bus.mmu_sys_signed_o, bus.mmu_wei_signed_o}));
      end
   end
   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic junk();
      bus.load_wei_i   = 1'($urandom);
      bus.wei_signed_i = 1'($urandom);
      bus.sys_signed_i = 1'($urandom);
      bus.accumulate_i = 1'($urandom);
      bus.wei_base_i   = 16'($urandom);
      bus.in_base_i    = 16'($urandom);
      bus.acc_base_i   = 16'($urandom);
      bus.num_vec_i    = 16'($urandom_range(1, 9));
   endtask
   // Expected timeline: start sampled in cycle s, weights occupy MW cycles, each vector's
   // result appears RL cycles after its read, done follows the last result.
   task automatic run_job(input bit lw, input bit ws, input bit ss, input bit ac, input int wb,
                          input int ib, input int ab, input int n, input bit mid_start, input int rst_at);
      int s, f, d;
      @(posedge clk);
      #1;
      bus.start_i      = 1'b1;
      bus.load_wei_i   = lw;
      bus.wei_signed_i = ws;
      bus.sys_signed_i = ss;
      bus.accumulate_i = ac;
      bus.wei_base_i   = 16'(wb);
      bus.in_base_i    = 16'(ib);
      bus.acc_base_i   = 16'(ab);
      bus.num_vec_i    = 16'(n);
      s = cyc;
      f = lw ? s + 1 + MW : s + 1;
      if (lw) for (int r = 0; r < MW; r++) begin
         push(0, s + 1 + r, (wb + r) & MASK);
         push(1, s + 2 + r, r);
      end
      for (int k = 0; k < n; k++) begin
         push(2, f + k, (ib + k) & MASK);
         push(4, f + k + RL, ((ab + k) & MASK) | (int'(ac) << 16));
      end
      if (lw && n > 0) push(3, f + 1, 0);
      d = n > 0 ? f + n + RL : f;
      push(5, d, int'(ws) | (int'(ss) << 1));
      busy_lo = s + 1;
      busy_hi = d;
      cur_ss  = ss;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      junk();
      if (mid_start) begin
         wait_until(f + 2);
         bus.start_i = 1'b1;
         junk();
         bus.load_wei_i = 1'b1;
         @(posedge clk);
         #1;
         bus.start_i = 1'b0;
      end
      if (rst_at > 0) begin
         wait_until(f + rst_at);
         rstn_i = 1'b0;
         for (int i = 0; i < 6; i++) evq[i].delete();
         busy_hi = 0;
         repeat (3) @(posedge clk);
         #1;
         rstn_i = 1'b1;
         repeat (40) @(posedge clk);
         #1;
      end else begin
         wait_until(d + 1);
      end
   endtask
   initial begin
      bus.start_i = 1'b0;
      junk();
      #2 rstn_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn_i = 1'b1;
      run_job(1, 0, 0, 0, 'h10, 'h100, 'h40, 4, 0, 0);
      run_job(0, 0, 1, 1, 'h20, 'h200, 'h80, 3, 0, 0);
      run_job(1, 1, 0, 0, 'h30, 'h300, 'h10, 0, 0, 0);
      run_job(0, 0, 0, 1, 'h40, 'h400, 'h20, 4, 1, 0);
      run_job(0, 1, 1, 0, 'h50, 'h500, 'h30, 8, 0, 3);
      run_job(1, 0, 1, 1, 'hFFF8, 'hFFFE, 'hFFFD, 5, 0, 0);
      run_job(0, 1, 0, 1, 'h60, 'h600, 'h70, 1, 0, 0);
      for (int j = 0; j < 6; j++)
         run_job(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), int'(16'($urandom)),
                 int'(16'($urandom)), int'(16'($urandom)), $urandom_range(0, 35), 0, 0);
      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (evq[i].size() != 0) begin
            errors++;
            $display("FAIL %s leftover got %0d pending, required 0 (next at cycle %0d)", nm[i], evq[i].size(), evq[i][0].c);
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog got timeout at cycle %0d, required completion", cyc);
      $fatal(1);
   end
endmodule
